// File: rtl/btn_event_ctrl_pkg.sv
// Shared constants for the button event controller: button count, FSM encodings, helpers.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package btn_event_ctrl_pkg;

  localparam int NUM_BTN = 4;
  localparam int OWN_W   = $clog2(NUM_BTN);

  typedef logic [OWN_W-1:0] own_t;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRESS    = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  function automatic own_t lowest_set(input logic [NUM_BTN-1:0] v);
    own_t r;
    r = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) r = own_t'(i);
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_ctrl_tick_gen.sv
// Free-running prescaler: counts 0..TICK_CNT-1 and flags the wrap cycle as a tick.
// Latency: oTick is a decode of the counter register, high for one cycle every TICK_CNT cycles.
// Backpressure: none; runs unconditionally.
module tick_gen #(
  parameter int TICK_CNT = 100000
) (
  input  logic iClk,
  input  logic iRst,
  output logic oTick
);

  localparam int CW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CNT - 1);

  logic [CW-1:0] cnt;

  // Wrap at TICK_CNT-1 so the period is exactly TICK_CNT cycles.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign oTick = (cnt == LAST);

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller: turns debounced levels into short / long / auto-repeat pulses.
// Latency: every event pulse is registered, one cycle after the qualifying iBtn sample or tick.
// Backpressure: none; events are fire-and-forget one-cycle pulses.
module btn_event_ctrl
  import btn_event_ctrl_pkg::*;
#(
  parameter int TICK_CNT   = 100000,
  parameter int LONG_TICKS = 1000,
  parameter int RPT_TICKS  = 200
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [NUM_BTN-1:0] iBtn,
  output logic [NUM_BTN-1:0] oShort,
  output logic [NUM_BTN-1:0] oLong,
  output logic [NUM_BTN-1:0] oRpt,
  output logic               oBusy
);

  localparam int HW = $clog2(max_int(LONG_TICKS, RPT_TICKS) + 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'(RPT_TICKS - 1);

  logic              tick;
  logic [1:0]        state, nxt_state;
  own_t              owner, nxt_owner;
  logic [HW-1:0]     hold_cnt, nxt_cnt;
  logic [NUM_BTN-1:0] nxt_short, nxt_long, nxt_rpt;
  logic [NUM_BTN-1:0] owner_oh;
  logic              owner_held;

  tick_gen #(.TICK_CNT(TICK_CNT)) u_tick (
    .iClk  (iClk),
    .iRst  (iRst),
    .oTick (tick)
  );

  assign owner_oh   = NUM_BTN'(1) << owner;
  assign owner_held = iBtn[owner];

  // Next-state and event decode; release is tested before the tick so it wins ties.
  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_cnt   = hold_cnt;
    nxt_short = '0;
    nxt_long  = '0;
    nxt_rpt   = '0;
    case (state)
      ST_IDLE: begin
        if (|iBtn) begin
          nxt_owner = lowest_set(iBtn);
          nxt_cnt   = '0;
          nxt_state = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (!owner_held) begin
          nxt_short = owner_oh;
          nxt_state = ST_WAIT_REL;
        end else if (tick) begin
          if (hold_cnt == LONG_LAST) begin
            nxt_long  = owner_oh;
            nxt_cnt   = '0;
            nxt_state = ST_HOLD;
          end else begin
            nxt_cnt = hold_cnt + HW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (!owner_held) begin
          nxt_state = ST_WAIT_REL;
        end else if (tick) begin
          if (hold_cnt == RPT_LAST) begin
            nxt_rpt = owner_oh;
            nxt_cnt = '0;
          end else begin
            nxt_cnt = hold_cnt + HW'(1);
          end
        end
      end
      ST_WAIT_REL: begin
        if (iBtn == '0) nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset discards any press in flight.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      hold_cnt <= '0;
      oShort   <= '0;
      oLong    <= '0;
      oRpt     <= '0;
      oBusy    <= 1'b0;
    end else begin
      state    <= nxt_state;
      owner    <= nxt_owner;
      hold_cnt <= nxt_cnt;
      oShort   <= nxt_short;
      oLong    <= nxt_long;
      oRpt     <= nxt_rpt;
      oBusy    <= (nxt_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with TICK_CNT=4, LONG_TICKS=10, RPT_TICKS=3.
// Latency: tick n of a press lands on edge 4n after reset release; events show one edge later.
// Backpressure: n/a.
module tb_btn_event_ctrl;

  logic       iClk;
  logic       iRst;
  logic [3:0] iBtn;
  logic [3:0] oShort, oLong, oRpt;
  logic       oBusy;

  btn_event_ctrl #(.TICK_CNT(4), .LONG_TICKS(10), .RPT_TICKS(3)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iBtn   (iBtn),
    .oShort (oShort),
    .oLong  (oLong),
    .oRpt   (oRpt),
    .oBusy  (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [3:0] btn;
    int         hold;     // edges for which btn is sampled pressed
    int         n_short;
    int         n_long;
    int         n_rpt;
    logic [3:0] bits;     // OR of every event bit seen
    int         first;    // edge of first event (0 = none)
    int         last;     // edge of last event
  } vec_t;

  vec_t vecs[10];

  int n_cmp, n_miss;
  int edge_i;
  int a_short, a_long, a_rpt, a_first, a_last;
  logic [3:0] a_bits;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_acc();
    a_short = 0; a_long = 0; a_rpt = 0; a_first = 0; a_last = 0; a_bits = '0;
  endtask

  // Advance n cycles, sampling outputs at each falling edge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge iClk);
      edge_i++;
      if ($countones({oShort, oLong, oRpt}) > 1) begin
        n_miss++;
        $display("FAIL onehot edge %0d: got %b/%b/%b, expected at most one bit", edge_i, oShort, oLong, oRpt);
      end
      if (|oShort) a_short++;
      if (|oLong)  a_long++;
      if (|oRpt)   a_rpt++;
      if (|{oShort, oLong, oRpt}) begin
        if (a_first == 0) a_first = edge_i;
        a_last = edge_i;
      end
      a_bits = a_bits | oShort | oLong | oRpt;
    end
  endtask

  // Reset, then release at a falling edge with btn applied so edge 1 is the first sample.
  task automatic do_reset(input logic [3:0] btn);
    iRst = 1'b1;
    iBtn = '0;
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    iBtn = btn;
    edge_i = 0;
    clr_acc();
  endtask

  initial begin
    n_cmp = 0; n_miss = 0; edge_i = 0;
    iRst = 1'b1;
    iBtn = '0;

    //          btn     hold  S  L  R  bits    first last
    vecs[0] = '{4'b0001, 20,  1, 0, 0, 4'b0001, 21,  21};
    vecs[1] = '{4'b0100, 80,  0, 1, 3, 4'b0100, 40,  76};
    vecs[2] = '{4'b0110, 20,  1, 0, 0, 4'b0010, 21,  21};
    vecs[3] = '{4'b0110, 44,  0, 1, 0, 4'b0010, 40,  40};
    vecs[4] = '{4'b0001, 39,  1, 0, 0, 4'b0001, 40,  40};
    vecs[5] = '{4'b0001, 40,  0, 1, 0, 4'b0001, 40,  40};
    vecs[6] = '{4'b1000, 51,  0, 1, 0, 4'b1000, 40,  40};
    vecs[7] = '{4'b1000, 52,  0, 1, 1, 4'b1000, 40,  52};
    vecs[8] = '{4'b1000, 1,   1, 0, 0, 4'b1000, 2,   2};
    vecs[9] = '{4'b1111, 4,   1, 0, 0, 4'b0001, 5,   5};

    // Reset state, with a button pressed to show reset dominates.
    @(negedge iClk);
    iBtn = 4'b0101;
    @(negedge iClk);
    chk("rst_short", int'(oShort), 0);
    chk("rst_long",  int'(oLong),  0);
    chk("rst_rpt",   int'(oRpt),   0);
    chk("rst_busy",  int'(oBusy),  0);

    for (int v = 0; v < 10; v++) begin
      do_reset(vecs[v].btn);
      run(vecs[v].hold);
      iBtn = '0;
      run(8);
      chk($sformatf("v%0d_short", v), a_short, vecs[v].n_short);
      chk($sformatf("v%0d_long",  v), a_long,  vecs[v].n_long);
      chk($sformatf("v%0d_rpt",   v), a_rpt,   vecs[v].n_rpt);
      chk($sformatf("v%0d_bits",  v), int'(a_bits), int'(vecs[v].bits));
      chk($sformatf("v%0d_first", v), a_first, vecs[v].first);
      chk($sformatf("v%0d_last",  v), a_last,  vecs[v].last);
      chk($sformatf("v%0d_busy",  v), int'(oBusy), 0);
    end

    // Busy timing around a short press.
    do_reset(4'b0001);
    run(20);
    chk("busy_pressed", int'(oBusy), 1);
    iBtn = '0;
    run(1);
    chk("busy_short_pulse", int'(oShort), 1);
    chk("busy_in_wait",     int'(oBusy),  1);
    run(1);
    chk("busy_fall",        int'(oBusy),  0);
    chk("busy_short_gone",  int'(oShort), 0);

    // Non-owner button keeps the FSM in WAIT_REL after owner release.
    do_reset(4'b0001);
    run(41);
    chk("nown_long", a_long, 1);
    clr_acc();
    iBtn = 4'b1001;
    run(8);
    iBtn = 4'b1000;
    run(30);
    chk("nown_events", a_short + a_long + a_rpt, 0);
    chk("nown_busy",   int'(oBusy), 1);
    iBtn = '0;
    run(1);
    chk("nown_idle",   int'(oBusy), 0);

    // Reset mid-press, released with the button still held.
    do_reset(4'b0001);
    run(28);
    chk("mrst_pre_events", a_short + a_long + a_rpt, 0);
    iRst = 1'b1;
    #1;
    chk("mrst_busy",  int'(oBusy), 0);
    chk("mrst_long",  int'(oLong), 0);
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    edge_i = 0;
    clr_acc();
    run(44);
    chk("mrst_long_cnt",  a_long,  1);
    chk("mrst_long_edge", a_first, 40);
    iBtn = '0;
    run(4);
    chk("mrst_short", a_short, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
